load_store_ctrl: RTL and testbench
==================================

LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req_valid  in  1  pipeline memory request present.
REQ-004 SHALL have ports: req_ready  out  1  controller can accept request.
REQ-005 SHALL have ports: req_we  in  1  1 = store, 0 = load.
REQ-006 SHALL have ports: req_op  in  3  000 word, 001 byte unsigned, 010 byte signed, 011 half unsigned, 100 half signed; 101-111 reserved.
REQ-007 SHALL have ports: req_addr  in  32  byte address; req_wdata  in  32  store data, low-aligned.
REQ-008 SHALL have ports: bus_req  out  1; bus_we  out  1; bus_addr  out  32  word-aligned; bus_be  out  4; bus_wdata  out  32.
REQ-009 SHALL have ports: bus_ack  in  1  access complete; bus_rdata  in  32  read word, valid with bus_ack.
REQ-010 SHALL have ports: resp_valid  out  1  one-cycle completion pulse; resp_data  out  32  extended load data; resp_exc  out  2  00 ok, 01 misaligned, 10 timeout, 11 bad op.
REQ-011 SHALL have parameter: TIMEOUT, default 16, maximum cycles in ACCESS awaiting bus_ack.

Function
REQ-012 SHALL implement FSM IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-013 SHALL accept a request on a rising edge with req_valid & req_ready, latching we, op, addr, wdata.
REQ-014 Accepted reserved op SHALL go IDLE->RESP with resp_exc = 11 and no bus access.
REQ-015 Accepted misaligned request (word with addr[1:0] != 0, half with addr[0] != 0) SHALL go IDLE->RESP with resp_exc = 01 and no bus access.
REQ-016 Otherwise SHALL go IDLE->ACCESS; bus_req = 1 throughout ACCESS, bus_addr = {addr[31:2], 2'b00}.
REQ-017 Store byte enables SHALL be: word 1111; half 0011 (addr[1] = 0) or 1100 (addr[1] = 1); byte 0001 shifted left by addr[1:0]; loads SHALL use 1111.
REQ-018 Store bus_wdata SHALL be: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-019 bus_ack in ACCESS SHALL capture bus_rdata and go to RESP.
REQ-020 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; reaching TIMEOUT SHALL go to RESP with resp_exc = 10.
REQ-021 bus_ack and timeout in the same cycle SHALL resolve as ack (exc 00).
REQ-022 In RESP, resp_valid = 1 for exactly one cycle, then IDLE; minimum load latency = accept + 1 ACCESS cycle + RESP = 3 cycles.
REQ-023 Load resp_data SHALL be the selected byte or half (by addr[1:0]) zero- or sign-extended per op; word unchanged.
REQ-024 resp_data SHALL be 0 for stores and for any resp_exc != 00.
REQ-025 bus_ack outside ACCESS SHALL be ignored.

Reset
REQ-026 Assertion of reset SHALL immediately force IDLE, counter 0, and bus_req, bus_we, resp_valid = 0; bus_be = 0000; bus_addr, bus_wdata, resp_data = 0; resp_exc = 00.
REQ-027 Reset during ACCESS SHALL abandon the access with no response issued.

Structure
REQ-028 Op encodings, exception codes and state encodings SHALL reside in a shared package.
REQ-029 Extension logic SHALL be one combinational sub-module, load_ext (inputs byte offset, op, word; output 32-bit result).

Verification
REQ-030 lb at addr 0x1003, bus_rdata 0x80FF_1234 acked first ACCESS cycle -> resp_data 0xFFFF_FF80, exc 00, resp_valid 3 cycles after accept.
REQ-031 sh at 0x2002, wdata 0x0000_ABCD -> bus_be 1100, bus_wdata 0xABCD_ABCD, bus_we 1, bus_addr 0x2000.
REQ-032 lw at 0x3001 -> no bus_req, resp_exc 01, resp_data 0.
REQ-033 lhu with bus_ack withheld -> bus_req drops after 16 cycles, resp_exc 10; ack exactly on cycle 16 -> exc 00.
REQ-034 Reset asserted mid-ACCESS -> bus_req 0 immediately, no resp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/load_store_ctrl_pkg.sv
// load_store_ctrl_pkg: shared encodings and store-lane helpers for the load/store controller
// Contents: op codes, exception codes, FSM state type, op/alignment and byte-lane helpers.
package load_store_ctrl_pkg;
  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_BU = 3'b001;
  localparam logic [2:0] OP_B  = 3'b010;
  localparam logic [2:0] OP_HU = 3'b011;
  localparam logic [2:0] OP_H  = 3'b100;
  localparam logic [1:0] EXC_OK  = 2'b00;
  localparam logic [1:0] EXC_MIS = 2'b01;
  localparam logic [1:0] EXC_TO  = 2'b10;
  localparam logic [1:0] EXC_BAD = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  function automatic logic is_half(input logic [2:0] op);
    return op == OP_HU || op == OP_H;
  endfunction
  function automatic logic is_byte(input logic [2:0] op);
    return op == OP_BU || op == OP_B;
  endfunction
  function automatic logic bad_op(input logic [2:0] op);
    return op > OP_H;
  endfunction
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    return (op == OP_W && off != 2'b00) || (is_half(op) && off[0]);
  endfunction
  function automatic logic [3:0] st_be(input logic [2:0] op, input logic [1:0] off);
    return op == OP_W ? 4'hf : is_half(op) ? (off[1] ? 4'hc : 4'h3) : 4'h1 << off;
  endfunction
  function automatic logic [31:0] st_data(input logic [2:0] op, input logic [31:0] w);
    return is_byte(op) ? {4{w[7:0]}} : is_half(op) ? {2{w[15:0]}} : w;
  endfunction
endpackage

// File: rtl/load_store_ctrl_load_ext.sv
// load_ext: selects the addressed byte/half of a read word and zero- or sign-extends it
// Ports: off (byte offset), op (access op), word (bus read word), result (extended value).
module load_ext
  import load_store_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  input  logic [31:0] word,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    result = op == OP_BU ? {24'b0, b} :
             op == OP_B  ? {{24{b[7]}}, b} :
             op == OP_HU ? {16'b0, h} :
             op == OP_H  ? {{16{h[15]}}, h} : word;
  end
endmodule

// File: rtl/load_store_ctrl.sv
// load_store_ctrl: single-outstanding load/store controller between a pipeline and a word bus
// Ports: req_* pipeline request (valid/ready, we, op, byte addr, wdata);
//        bus_* word-aligned bus master (req, we, addr, be, wdata, ack, rdata);
//        resp_* one-cycle completion (valid, extended data, exception code).
module load_store_ctrl
  import load_store_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_exc
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [1:0]    off_q;
  logic          we_q;
  logic [31:0]   ext;
  assign req_ready = state == S_IDLE;
  load_ext u_ext (.off(off_q), .op(op_q), .word(bus_rdata), .result(ext));
  // bus_addr/bus_wdata double as the latched request address and store data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      off_q      <= '0;
      we_q       <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_exc   <= EXC_OK;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_q      <= req_op;
          off_q     <= req_addr[1:0];
          we_q      <= req_we;
          cnt       <= '0;
          resp_data <= '0;
          if (bad_op(req_op) || misaligned(req_op, req_addr[1:0])) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_exc   <= bad_op(req_op) ? EXC_BAD : EXC_MIS;
          end else begin
            state     <= S_ACCESS;
            bus_req   <= 1'b1;
            bus_we    <= req_we;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_be    <= req_we ? st_be(req_op, req_addr[1:0]) : 4'hf;
            bus_wdata <= st_data(req_op, req_wdata);
          end
        end
        S_ACCESS: if (bus_ack || cnt == CW'(TIMEOUT - 1)) begin
          // ack wins over a simultaneous timeout
          state      <= S_RESP;
          bus_req    <= 1'b0;
          bus_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_exc   <= bus_ack ? EXC_OK : EXC_TO;
          resp_data  <= bus_ack && !we_q ? ext : '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_ctrl.sv
// tb_load_store_ctrl: table-driven and directed self-checking bench for load_store_ctrl
module tb_load_store_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_exc;
  int checks = 0;
  int failures = 0;
  int vi = -1;
  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bus;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] data;
    logic [1:0]  exc;
  } vec_t;
  vec_t v[18];
  load_store_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_exc(resp_exc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (vec %0d) actual=%h required=%h", name, vi, act, exp);
    end
  endtask
  task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask
  task automatic run_vec(input vec_t t);
    do_req(t.we, t.op, t.addr, t.wdata);
    chk("ready_busy", req_ready, 0);
    if (t.bus) begin
      chk("bus_req", bus_req, 1);
      chk("bus_we", bus_we, t.we);
      chk("bus_addr", bus_addr, t.baddr);
      chk("bus_be", bus_be, t.be);
      if (t.we) chk("bus_wdata", bus_wdata, t.bwdata);
      chk("resp_early", resp_valid, 0);
      bus_ack = 1'b1; bus_rdata = t.rdata;
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    chk("bus_req_off", bus_req, 0);
    chk("resp_valid", resp_valid, 1);
    chk("resp_data", resp_data, t.data);
    chk("resp_exc", resp_exc, t.exc);
    @(posedge clk); #1;
    chk("resp_pulse", resp_valid, 0);
    chk("ready_back", req_ready, 1);
  endtask
  initial begin
    int n;
    v[0]  = '{1'b0, 3'b010, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1'b1, 32'h0000_1000, 4'hf, 32'h0, 32'hFFFF_FF80, 2'b00};
    v[1]  = '{1'b0, 3'b001, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1'b1, 32'h0000_1000, 4'hf, 32'h0, 32'h0000_0080, 2'b00};
    v[2]  = '{1'b0, 3'b001, 32'h0000_1001, 32'h0, 32'h80FF_1234, 1'b1, 32'h0000_1000, 4'hf, 32'h0, 32'h0000_0012, 2'b00};
    v[3]  = '{1'b0, 3'b100, 32'h0000_1002, 32'h0, 32'h80FF_1234, 1'b1, 32'h0000_1000, 4'hf, 32'h0, 32'hFFFF_80FF, 2'b00};
    v[4]  = '{1'b0, 3'b011, 32'h0000_1002, 32'h0, 32'h80FF_1234, 1'b1, 32'h0000_1000, 4'hf, 32'h0, 32'h0000_80FF, 2'b00};
    v[5]  = '{1'b0, 3'b100, 32'h0000_1000, 32'h0, 32'h80FF_1234, 1'b1, 32'h0000_1000, 4'hf, 32'h0, 32'h0000_1234, 2'b00};
    v[6]  = '{1'b0, 3'b000, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'h0000_1004, 4'hf, 32'h0, 32'hDEAD_BEEF, 2'b00};
    v[7]  = '{1'b1, 3'b100, 32'h0000_2002, 32'h0000_ABCD, 32'hFFFF_FFFF, 1'b1, 32'h0000_2000, 4'hc, 32'hABCD_ABCD, 32'h0, 2'b00};
    v[8]  = '{1'b1, 3'b001, 32'h0000_2001, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 32'h0000_2000, 4'h2, 32'h7878_7878, 32'h0, 2'b00};
    v[9]  = '{1'b1, 3'b000, 32'h0000_2008, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1, 32'h0000_2008, 4'hf, 32'hCAFE_F00D, 32'h0, 2'b00};
    v[10] = '{1'b1, 3'b011, 32'h0000_2000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 32'h0000_2000, 4'h3, 32'h5678_5678, 32'h0, 2'b00};
    v[11] = '{1'b1, 3'b010, 32'h0000_2003, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b1, 32'h0000_2000, 4'h8, 32'hA5A5_A5A5, 32'h0, 2'b00};
    v[12] = '{1'b0, 3'b000, 32'h0000_3001, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b01};
    v[13] = '{1'b0, 3'b100, 32'h0000_3003, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b01};
    v[14] = '{1'b1, 3'b011, 32'h0000_3001, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b01};
    v[15] = '{1'b0, 3'b101, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b11};
    v[16] = '{1'b1, 3'b111, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b11};
    v[17] = '{1'b0, 3'b110, 32'h0000_3001, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b11};
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_exc", resp_exc, 0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 18; i++) begin
      vi = i;
      run_vec(v[i]);
    end
    vi = 100;
    do_req(1'b0, 3'b011, 32'h0000_5002, 32'h0);
    n = 0;
    while (bus_req && n < 40) begin
      n++;
      chk("to_no_resp", resp_valid, 0);
      @(posedge clk); #1;
    end
    chk("to_cycles", n, 16);
    chk("to_valid", resp_valid, 1);
    chk("to_exc", resp_exc, 2'b10);
    chk("to_data", resp_data, 0);
    @(posedge clk); #1;
    vi = 101;
    do_req(1'b0, 3'b011, 32'h0000_5002, 32'h0);
    repeat (15) @(posedge clk);
    #1;
    chk("ack16_req", bus_req, 1);
    bus_ack = 1'b1; bus_rdata = 32'hBEEF_0000;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("ack16_valid", resp_valid, 1);
    chk("ack16_exc", resp_exc, 2'b00);
    chk("ack16_data", resp_data, 32'h0000_BEEF);
    @(posedge clk); #1;
    vi = 102;
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      n += int'(resp_valid) + int'(bus_req);
    end
    bus_ack = 1'b0;
    chk("stray_ack", n, 0);
    chk("stray_ready", req_ready, 1);
    vi = 103;
    do_req(1'b0, 3'b000, 32'h0000_6000, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_be", bus_be, 0);
    chk("mid_rst_addr", bus_addr, 0);
    @(negedge clk); reset = 1'b1;
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      n += int'(resp_valid) + int'(bus_req);
    end
    chk("mid_rst_quiet", n, 0);
    chk("mid_rst_ready", req_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
